// File: rtl/spr_mux_n.sv
// Multi-sprite compositor: overlays NUM_SPR colour-keyed sprites on the VRAM background
// with fixed index priority, frame-latched positions and a per-frame sprite-0 collision flag.
module spr_mux_n #(
    parameter int unsigned               NUM_SPR = 4,
    parameter int unsigned               SPR_W   = 32,
    parameter int unsigned               SPR_H   = 32,
    parameter int unsigned               COLOR_W = 9,
    parameter logic [COLOR_W-1:0]        TRANSP  = '0,
    parameter int unsigned               PIX_W   = 10
) (
    input  logic                                    clk_25mhz,
    input  logic                                    RST_N,
    input  logic [PIX_W-1:0]                        pixel_x,
    input  logic [PIX_W-1:0]                        pixel_y,
    input  logic                                    vga_block,
    input  logic                                    vga_end,
    input  logic [COLOR_W-1:0]                      vram_dat,
    input  logic [NUM_SPR-1:0]                      spr_en,
    input  logic [NUM_SPR-1:0]                      spr_flip,
    input  logic [NUM_SPR*PIX_W-1:0]                spr_x,
    input  logic [NUM_SPR*PIX_W-1:0]                spr_y,
    output logic [NUM_SPR*$clog2(SPR_W*SPR_H)-1:0]  spram_adr,
    input  logic [NUM_SPR*COLOR_W-1:0]              spram_dat,
    output logic [COLOR_W-1:0]                      vga_dat,
    output logic                                    vga_dat_vld,
    output logic                                    spr_coll
);

    localparam int unsigned CW = $clog2(SPR_W);
    localparam int unsigned RW = $clog2(SPR_H);
    localparam int unsigned AW = CW + RW;
    localparam int unsigned XW = PIX_W + 1;

    logic [NUM_SPR-1:0]       sh_en;
    logic [NUM_SPR-1:0]       sh_flip;
    logic [NUM_SPR*PIX_W-1:0] sh_x;
    logic [NUM_SPR*PIX_W-1:0] sh_y;

    logic [NUM_SPR-1:0]       hit_c;
    logic [NUM_SPR-1:0]       hit_d;
    logic [NUM_SPR-1:0]       opq_c;
    logic                     blk_d;
    logic                     coll_live;
    logic                     coll_c;
    logic [COLOR_W-1:0]       pix_c;

    logic [XW-1:0]            px;
    logic [XW-1:0]            py;
    logic [XW-1:0]            sx;
    logic [XW-1:0]            sy;
    logic                     in_x;
    logic                     in_y;
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;

    // Sprite attributes only change at frame boundaries
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            sh_en   <= '0;
            sh_flip <= '0;
            sh_x    <= '0;
            sh_y    <= '0;
        end else if (vga_end) begin
            sh_en   <= spr_en;
            sh_flip <= spr_flip;
            sh_x    <= spr_x;
            sh_y    <= spr_y;
        end
    end

    // Stage 0: hit test with one extra bit so right/bottom edges clip instead of wrapping
    always_comb begin
        hit_c     = '0;
        spram_adr = '0;
        px        = {1'b0, pixel_x};
        py        = {1'b0, pixel_y};
        sx        = '0;
        sy        = '0;
        in_x      = 1'b0;
        in_y      = 1'b0;
        col       = '0;
        row       = '0;
        for (int i = 0; i < int'(NUM_SPR); i++) begin
            sx   = {1'b0, sh_x[i*PIX_W +: PIX_W]};
            sy   = {1'b0, sh_y[i*PIX_W +: PIX_W]};
            in_x = (px >= sx) && (px < sx + XW'(SPR_W));
            in_y = (py >= sy) && (py < sy + XW'(SPR_H));
            hit_c[i] = sh_en[i] && in_x && in_y && vga_block;
            col = CW'(pixel_x - sh_x[i*PIX_W +: PIX_W]);
            if (sh_flip[i]) begin
                col = CW'(SPR_W - 1) - col;
            end
            row = RW'(pixel_y - sh_y[i*PIX_W +: PIX_W]);
            if (hit_c[i]) begin
                spram_adr[i*AW +: AW] = {row, col};
            end
        end
    end

    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            hit_d <= '0;
            blk_d <= 1'b0;
        end else begin
            hit_d <= hit_c;
            blk_d <= vga_block;
        end
    end

    // Stage 1: lowest-index opaque sprite wins over the background
    always_comb begin
        opq_c = '0;
        pix_c = vram_dat;
        for (int i = 0; i < int'(NUM_SPR); i++) begin
            opq_c[i] = hit_d[i] && (spram_dat[i*COLOR_W +: COLOR_W] != TRANSP);
        end
        for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
            if (opq_c[i]) begin
                pix_c = spram_dat[i*COLOR_W +: COLOR_W];
            end
        end
        coll_c = opq_c[0] && (|(opq_c >> 1));
    end

    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            vga_dat     <= '0;
            vga_dat_vld <= 1'b0;
        end else begin
            vga_dat     <= blk_d ? pix_c : '0;
            vga_dat_vld <= blk_d;
        end
    end

    // Collision accumulates over the frame and is published on the end-of-frame pulse
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            coll_live <= 1'b0;
            spr_coll  <= 1'b0;
        end else if (vga_end) begin
            spr_coll  <= coll_live | coll_c;
            coll_live <= 1'b0;
        end else if (coll_c) begin
            coll_live <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spr_mux_n.sv
// Randomised bench for spr_mux_n: a pixel-level reference model feeds a scoreboard queue
// that a separate monitor drains whenever the compositor presents a valid pixel.
module tb_spr_mux_n;

    localparam int unsigned NS  = 4;
    localparam int unsigned SW  = 32;
    localparam int unsigned SH  = 32;
    localparam int unsigned CWD = 9;
    localparam int unsigned PW  = 10;
    localparam int unsigned AW  = 10;

    logic              clk_25mhz = 1'b0;
    logic              RST_N     = 1'b0;
    logic [PW-1:0]     pixel_x;
    logic [PW-1:0]     pixel_y;
    logic              vga_block;
    logic              vga_end;
    logic [CWD-1:0]    vram_dat;
    logic [NS-1:0]     spr_en;
    logic [NS-1:0]     spr_flip;
    logic [NS*PW-1:0]  spr_x;
    logic [NS*PW-1:0]  spr_y;
    logic [NS*AW-1:0]  spram_adr;
    logic [NS*CWD-1:0] spram_dat;
    logic [CWD-1:0]    vga_dat;
    logic              vga_dat_vld;
    logic              spr_coll;

    always #5 clk_25mhz = ~clk_25mhz;

    spr_mux_n #(
        .NUM_SPR (NS),
        .SPR_W   (SW),
        .SPR_H   (SH),
        .COLOR_W (CWD),
        .TRANSP  (9'h000),
        .PIX_W   (PW)
    ) dut (
        .clk_25mhz   (clk_25mhz),
        .RST_N       (RST_N),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .vga_block   (vga_block),
        .vga_end     (vga_end),
        .vram_dat    (vram_dat),
        .spr_en      (spr_en),
        .spr_flip    (spr_flip),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spram_adr   (spram_adr),
        .spram_dat   (spram_dat),
        .vga_dat     (vga_dat),
        .vga_dat_vld (vga_dat_vld),
        .spr_coll    (spr_coll)
    );

    logic [CWD-1:0] mem [NS][SW*SH];
    int             m_en   [NS];
    int             m_flip [NS];
    int             m_x    [NS];
    int             m_y    [NS];
    logic [CWD-1:0] sb_q [$];
    bit             exp_coll;
    bit             frame_coll;
    int             checks;
    int             errors;

    function automatic logic [CWD-1:0] bg(input int x, input int y);
        return CWD'((x * 7) ^ (y * 13));
    endfunction

    // External sprite RAMs and VRAM, both with one cycle of read latency
    always @(posedge clk_25mhz) begin
        for (int i = 0; i < int'(NS); i++) begin
            spram_dat[i*CWD +: CWD] <= mem[i][spram_adr[i*AW +: AW]];
        end
        vram_dat <= bg(int'(pixel_x), int'(pixel_y));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: screen-space rectangle test, then walk sprites in priority order
    function automatic void model_px(input int x, input int y, input bit blk,
                                     output logic [CWD-1:0] dat,
                                     output logic [NS*AW-1:0] adr, output bit coll);
        bit found = 0;
        bit o0    = 0;
        bit oth   = 0;
        int c;
        int r;
        int a;
        dat = bg(x, y);
        adr = '0;
        for (int i = 0; i < int'(NS); i++) begin
            if (blk && m_en[i] != 0 && x >= m_x[i] && x < m_x[i] + int'(SW)
                    && y >= m_y[i] && y < m_y[i] + int'(SH)) begin
                c = x - m_x[i];
                if (m_flip[i] != 0) c = int'(SW) - 1 - c;
                r = y - m_y[i];
                a = r * int'(SW) + c;
                adr[i*AW +: AW] = AW'(a);
                if (mem[i][a] != '0) begin
                    if (!found) dat = mem[i][a];
                    found = 1;
                    if (i == 0) o0 = 1;
                    else        oth = 1;
                end
            end
        end
        coll = o0 && oth;
    endfunction

    function automatic int rand_x();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 639));
            1:       return 100 + int'($urandom_range(0, 40));
            2:       return int'($urandom_range(1000, 1023));
            default: return int'($urandom_range(600, 639));
        endcase
    endfunction

    function automatic int rand_y();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(990, 1023));
        return 100 + int'($urandom_range(0, 40));
    endfunction

    task automatic randomize_cfg();
        for (int i = 0; i < int'(NS); i++) begin
            spr_en[i]           = ($urandom_range(0, 4) != 0);
            spr_flip[i]         = 1'($urandom_range(0, 1));
            spr_x[i*PW +: PW]   = PW'(rand_x());
            spr_y[i*PW +: PW]   = PW'(rand_y());
        end
    endtask

    // Drives one pixel at the current falling edge and records what it must produce
    task automatic step(input int x, input int y, input bit blk, input bit e);
        logic [CWD-1:0]   edat;
        logic [NS*AW-1:0] eadr;
        bit               c;
        pixel_x   = PW'(x);
        pixel_y   = PW'(y);
        vga_block = blk;
        vga_end   = e;
        model_px(x, y, blk, edat, eadr, c);
        #1;
        check("spram_adr", 64'(spram_adr), 64'(eadr));
        if (blk) begin
            sb_q.push_back(edat);
            if (c) frame_coll = 1;
        end
    endtask

    task automatic do_reset();
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_vga_dat", 64'(vga_dat), 64'(0));
        check("rst_vga_dat_vld", 64'(vga_dat_vld), 64'(0));
        check("rst_spr_coll", 64'(spr_coll), 64'(0));
        sb_q.delete();
        for (int i = 0; i < int'(NS); i++) begin
            m_en[i] = 0; m_flip[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        frame_coll = 0;
        exp_coll   = 0;
        vga_block  = 1'b0;
        vga_end    = 1'b0;
        repeat (3) @(negedge clk_25mhz);
        RST_N = 1'b1;
    endtask

    task automatic run_frame(input int n, input int junk_at, input int reset_at);
        int x;
        int y;
        int k;
        for (int p = 0; p < n; p++) begin
            @(negedge clk_25mhz);
            if (p == junk_at) randomize_cfg();
            if (p == reset_at) do_reset();
            if ($urandom_range(0, 4) == 0) begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 1023));
            end else begin
                k = int'($urandom_range(0, NS - 1));
                x = (m_x[k] + int'($urandom_range(0, 39)) - 4) & 1023;
                y = (m_y[k] + int'($urandom_range(0, 39)) - 4) & 1023;
            end
            step(x, y, ($urandom_range(0, 9) != 0), 1'b0);
        end
        repeat (3) begin
            @(negedge clk_25mhz);
            step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 1'b0);
        end
        @(negedge clk_25mhz);
        randomize_cfg();
        step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 1'b1);
        for (int i = 0; i < int'(NS); i++) begin
            m_en[i]   = int'(spr_en[i]);
            m_flip[i] = int'(spr_flip[i]);
            m_x[i]    = int'(spr_x[i*PW +: PW]);
            m_y[i]    = int'(spr_y[i*PW +: PW]);
        end
        exp_coll   = frame_coll;
        frame_coll = 0;
        repeat (2) begin
            @(negedge clk_25mhz);
            step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 1'b0);
        end
    endtask

    // Monitor: pops the scoreboard whenever a valid pixel appears
    initial begin
        logic [CWD-1:0] e;
        forever begin
            @(posedge clk_25mhz);
            #1;
            if (RST_N) begin
                if (vga_dat_vld) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pixel: got %0h expected none at %0t", vga_dat, $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("vga_dat", 64'(vga_dat), 64'(e));
                    end
                end else begin
                    check("vga_dat_idle", 64'(vga_dat), 64'(0));
                end
                check("spr_coll", 64'(spr_coll), 64'(exp_coll));
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        exp_coll   = 0;
        frame_coll = 0;
        pixel_x    = '0;
        pixel_y    = '0;
        vga_block  = 1'b0;
        vga_end    = 1'b0;
        spr_en     = '0;
        spr_flip   = '0;
        spr_x      = '0;
        spr_y      = '0;
        for (int i = 0; i < int'(NS); i++) begin
            m_en[i] = 0; m_flip[i] = 0; m_x[i] = 0; m_y[i] = 0;
            for (int a = 0; a < int'(SW * SH); a++) begin
                mem[i][a] = ($urandom_range(0, 3) == 0) ? '0 : CWD'($urandom_range(1, 511));
            end
        end
        repeat (3) @(negedge clk_25mhz);
        #1;
        check("init_vga_dat", 64'(vga_dat), 64'(0));
        check("init_vga_dat_vld", 64'(vga_dat_vld), 64'(0));
        check("init_spr_coll", 64'(spr_coll), 64'(0));
        @(negedge clk_25mhz);
        RST_N = 1'b1;

        // Inputs carry live sprites, but shadows stay cleared until the first frame end
        run_frame(200, 0, -1);
        for (int f = 0; f < 12; f++) begin
            run_frame(250, int'($urandom_range(50, 200)), (f == 6) ? 120 : -1);
        end

        for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge clk_25mhz);
        check("drain", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spr_mux_n.md
# spr_mux_n

Multi-sprite compositor for the VGA path, sitting between the VGA timing controller and the RGB output pins. It overlays up to NUM_SPR hardware sprites of parametrised size on the VRAM background, with fixed index priority, colour-key transparency, per-sprite horizontal flip, frame-synchronous position latching and a per-frame collision flag. Sprite pixel memories stay outside the block: it drives one read address per sprite and consumes 1-cycle-latency read data.

## Interface
Parameters:
- NUM_SPR, 4, number of sprites (1..8); index 0 has highest priority
- SPR_W, 32, sprite width in pixels, power of two (8..64)
- SPR_H, 32, sprite height in pixels, power of two (8..64)
- COLOR_W, 9, pixel colour width (3R+3G+3B)
- TRANSP, 0, colour key treated as transparent
- PIX_W, 10, width of pixel_x, pixel_y and position inputs

Ports:
- clk_25mhz  in  1  pixel clock; the block has one clock
- RST_N  in  1  asynchronous, active-low reset
- pixel_x  in  PIX_W  current scan x, valid when vga_block=1
- pixel_y  in  PIX_W  current scan y
- vga_block  in  1  scan is inside the 640x480 active area
- vga_end  in  1  one-cycle end-of-frame pulse
- vram_dat  in  COLOR_W  background colour for the pixel issued one cycle earlier
- spr_en  in  NUM_SPR  per-sprite enable (shadowed)
- spr_flip  in  NUM_SPR  per-sprite horizontal mirror (shadowed)
- spr_x  in  NUM_SPR*PIX_W  packed x positions, sprite i at [i*PIX_W +: PIX_W] (shadowed)
- spr_y  in  NUM_SPR*PIX_W  packed y positions (shadowed)
- spram_adr  out  NUM_SPR*log2(SPR_W*SPR_H)  packed sprite RAM addresses, {row, col}
- spram_dat  in  NUM_SPR*COLOR_W  packed sprite RAM read data, 1-cycle latency
- vga_dat  out  COLOR_W  composited pixel colour
- vga_dat_vld  out  1  vga_block delayed to align with vga_dat
- spr_coll  out  1  sprite 0 overlapped an opaque pixel of another sprite last frame

## Operation
- Shadow registers: spr_en, spr_flip, spr_x and spr_y are copied into shadow registers on the vga_end cycle. All compositing uses the shadows, so mid-frame input changes have no effect until the next vga_end.
- Stage 0 (pixel cycle): per sprite, hit_i = en_i && pixel_x >= x_i && pixel_x < x_i+SPR_W && pixel_y >= y_i && pixel_y < y_i+SPR_H && vga_block.
  - All compares use PIX_W+1 bits so x_i+SPR_W never wraps. A sprite at x=1020 is clipped, not wrapped to column 0.
- Address generation:
  - col = pixel_x - x_i, or SPR_W-1-(pixel_x-x_i) when flip_i=1; row = pixel_y - y_i.
  - spram_adr_i = {row[log2 SPR_H-1:0], col[log2 SPR_W-1:0]}; the address is 0 when hit_i=0.
- Stage 1: hit vector and vga_block are registered one cycle so they align with spram_dat and vram_dat.
  - A sprite is opaque when hit_d_i=1 and spram_dat_i != TRANSP.
  - vga_dat takes the lowest-index opaque sprite; if no sprite is opaque it takes vram_dat. It is 0 when the delayed vga_block=0.
- Collision:
  - coll_live is set on any stage-1 cycle where sprite 0 is opaque and at least one other sprite is opaque.
  - On vga_end: spr_coll <= coll_live | (set condition this cycle), and coll_live is cleared.
- NUM_SPR=1: spr_coll stays 0.

## Timing
- Latency: pixel presented at cycle t gives vga_dat and vga_dat_vld at t+2. spram_adr is combinational from pixel_x in cycle t.
- Caller contract: spram_dat and vram_dat for the pixel of cycle t are valid during cycle t+1.
- Throughput: one pixel per clock, no stalls, no backpressure.
- Reset (RST_N=0, asynchronous), with all registers returning to these values immediately:
  - vga_dat=0, vga_dat_vld=0, spr_coll=0, coll_live=0
  - all shadows 0, so every sprite is disabled until the first vga_end after reset
- Reset released mid-frame: output is background only until the next vga_end.
- vga_end coinciding with an input change: the new input value is captured.

## Test plan
- Single sprite, en=1, x=y=100, RAM all 9'h1C0, background 9'h007 -> vga_dat=9'h1C0 for x,y in 100..131 (2-cycle delay), 9'h007 elsewhere.
- Transparency: sprite RAM column 0 = TRANSP (0) -> screen column 100 shows background 9'h007, columns 101..131 show sprite.
- Priority/collision: sprite 0 at (50,50) colour 9'h038, sprite 1 at (60,60) colour 9'h1FF -> overlap shows 9'h038; spr_coll=1 after the next vga_end, and 0 after a following frame with sprite 1 moved to (300,300).
- Flip: sprite RAM col = index value, flip=1 at x=0 -> pixel_x=0 reads spram_adr col 31, pixel_x=31 reads col 0.
- Shadowing/clipping: change spr_x from 10 to 620 mid-frame -> current frame still at x=10; next frame shows columns 620..639 only, nothing at column 0..11.
- Reset mid-frame: assert RST_N=0 at line 200 -> vga_dat=0 and spr_coll=0 immediately; after release, no sprite is shown until the first vga_end.
